// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin arbiter sharing the write side of one asynchronous FIFO among
//   NUM_REQ requesters, entirely in the FIFO write-clock domain. One requester
//   is granted at a time for a burst of up to MAX_BURST beats. A beat is
//   written whenever the granted requester holds req and the FIFO is not full.
//
// Ports
//   wr_clk      FIFO write clock (rising edge)
//   reset       asynchronous, active-high reset
//   req         per-requester request level, held until the burst completes
//   req_data    requester i data in bits [i*WIDTH +: WIDTH]
//   req_last    marks the current beat of requester i as its final beat
//   grant       registered one-hot grant, zero when idle
//   ack         combinational; beat of requester i written this cycle
//   fifo_full   FIFO write-side full flag
//   fifo_wr_en  combinational FIFO write strobe
//   fifo_data   combinational FIFO write data
//   busy        registered; high while a grant is held
module fifo_wr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 8
) (
    input  logic                       wr_clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         grant,
    output logic [NUM_REQ-1:0]         ack,
    input  logic                       fifo_full,
    output logic                       fifo_wr_en,
    output logic [WIDTH-1:0]           fifo_data,
    output logic                       busy
);

    localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNTW = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t              state, state_nxt;
    logic [NUM_REQ-1:0]  grant_q, grant_nxt;
    logic [IDXW-1:0]     gidx, gidx_nxt;
    logic [IDXW-1:0]     rr_ptr, rr_ptr_nxt;
    logic [CNTW-1:0]     beat_cnt, beat_cnt_nxt;

    logic [2*NUM_REQ-1:0] rot;
    logic [IDXW-1:0]      off;
    logic                 found;
    logic [IDXW:0]        win_sum;
    logic [IDXW-1:0]      winner;

    logic                 sel_req;
    logic                 sel_last;
    logic [WIDTH-1:0]     sel_data;
    logic                 beat;

    // Rotate the request vector so rr_ptr sits at bit 0; the first set bit
    // then gives the offset of the winner from rr_ptr.
    always_comb begin
        rot   = {req, req} >> rr_ptr;
        off   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                off   = IDXW'(i);
            end
        end
        win_sum = {1'b0, rr_ptr} + {1'b0, off};
        if (win_sum >= (IDXW+1)'(NUM_REQ))
            winner = IDXW'(win_sum - (IDXW+1)'(NUM_REQ));
        else
            winner = win_sum[IDXW-1:0];
    end

    // Signals of the currently granted requester.
    always_comb begin
        sel_req  = 1'b0;
        sel_last = 1'b0;
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gidx == IDXW'(i)) begin
                sel_req  = req[i];
                sel_last = req_last[i];
                sel_data = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign beat       = (state == BURST) && sel_req && !fifo_full;
    assign fifo_wr_en = beat;
    assign ack        = beat ? grant_q : '0;
    assign fifo_data  = (state == BURST) ? sel_data : '0;
    assign grant      = grant_q;
    assign busy       = (state == BURST);

    always_comb begin
        state_nxt    = state;
        grant_nxt    = grant_q;
        gidx_nxt     = gidx;
        rr_ptr_nxt   = rr_ptr;
        beat_cnt_nxt = beat_cnt;
        unique case (state)
            IDLE: begin
                if (|req) begin
                    state_nxt    = BURST;
                    gidx_nxt     = winner;
                    beat_cnt_nxt = '0;
                    for (int unsigned i = 0; i < NUM_REQ; i++)
                        grant_nxt[i] = (winner == IDXW'(i));
                end
            end
            BURST: begin
                // Release on abandon, final beat, or the MAX_BURST-th beat;
                // a beat that is both last and MAX_BURST releases only once.
                if (!sel_req || (beat && (sel_last || beat_cnt == CNTW'(MAX_BURST - 1)))) begin
                    state_nxt  = IDLE;
                    grant_nxt  = '0;
                    rr_ptr_nxt = (gidx == IDXW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
                end
                if (beat)
                    beat_cnt_nxt = beat_cnt + 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wr_clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            grant_q  <= '0;
            gidx     <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            grant_q  <= grant_nxt;
            gidx     <= gidx_nxt;
            rr_ptr   <= rr_ptr_nxt;
            beat_cnt <= beat_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios with literal
// expectations, a fairness run, a mid-burst reset and a randomized phase, all
// compared every cycle against a behavioural arbitration model.
module tb_fifo_wr_arbiter;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int MB = 8;

    logic           wr_clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req, req_last, grant, ack;
    logic [N*W-1:0] req_data;
    logic           fifo_full, fifo_wr_en, busy;
    logic [W-1:0]   fifo_data;

    always #5 wr_clk = ~wr_clk;

    fifo_wr_arbiter #(.WIDTH(W), .NUM_REQ(N), .MAX_BURST(MB)) dut (
        .wr_clk(wr_clk), .reset(reset), .req(req), .req_data(req_data),
        .req_last(req_last), .grant(grant), .ack(ack), .fifo_full(fifo_full),
        .fifo_wr_en(fifo_wr_en), .fifo_data(fifo_data), .busy(busy)
    );

    int errors = 0;
    int checks = 0;

    // Model: owner = granted index or -1 when idle.
    int m_owner, m_ptr, m_beats;
    logic [W-1:0] dat [N];
    int wr_per [N];
    int rem [N];

    logic [N-1:0] o_grant, o_ack;
    logic         o_wr, o_busy;
    logic [W-1:0] o_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_beats = 0;
    endtask

    task automatic model_release();
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
    endtask

    // Compare DUT outputs against the model for the current cycle, then
    // advance the model across the coming clock edge.
    task automatic eval_cycle();
        logic [N-1:0] eg, ea;
        logic [W-1:0] ed;
        bit           bt;
        int           win;
        o_grant = grant; o_ack = ack; o_wr = fifo_wr_en;
        o_busy  = busy;  o_data = fifo_data;
        eg = '0; ed = '0; bt = 0;
        if (m_owner >= 0) begin
            eg[m_owner] = 1'b1;
            ed = req_data[m_owner*W +: W];
            bt = req[m_owner] && !fifo_full;
        end
        ea = bt ? eg : '0;
        chk("grant", 32'(o_grant), 32'(eg));
        chk("busy", 32'(o_busy), 32'(m_owner >= 0));
        chk("ack", 32'(o_ack), 32'(ea));
        chk("wr_en", 32'(o_wr), 32'(bt));
        chk("data", 32'(o_data), 32'(ed));
        for (int i = 0; i < N; i++) if (o_ack[i]) wr_per[i]++;
        if (m_owner < 0) begin
            win = -1;
            for (int k = 0; k < N; k++)
                if (win < 0 && req[(m_ptr + k) % N]) win = (m_ptr + k) % N;
            if (win >= 0) begin
                m_owner = win;
                m_beats = 0;
            end
        end else if (!req[m_owner]) begin
            model_release();
        end else if (bt) begin
            m_beats++;
            if (req_last[m_owner] || m_beats == MB) model_release();
        end
    endtask

    task automatic step(input logic [N-1:0] r, input logic [N-1:0] l, input logic f);
        @(posedge wr_clk);
        #1;
        req = r; req_last = l; fifo_full = f;
        for (int i = 0; i < N; i++) req_data[i*W +: W] = dat[i];
        @(negedge wr_clk);
        eval_cycle();
    endtask

    initial begin
        logic [N-1:0] r, l;
        logic         f;
        for (int i = 0; i < N; i++) begin
            dat[i] = W'(8'h10 + i);
            wr_per[i] = 0;
            rem[i] = 0;
        end
        reset = 1'b1; req = 4'b1111; req_last = '0; fifo_full = 1'b0;
        for (int i = 0; i < N; i++) req_data[i*W +: W] = dat[i];
        model_reset();
        @(negedge wr_clk);
        @(negedge wr_clk);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_wr_en", 32'(fifo_wr_en), 32'h0);
        chk("rst_data", 32'(fifo_data), 32'h0);
        reset = 1'b0;
        #1;
        req_last = 4'b1111;
        eval_cycle();

        // First grants after reset: 0 then 1.
        step(4'b1111, 4'b1111, 1'b0);
        chk("first_grant", 32'(o_grant), 32'b0001);
        chk("first_wr", 32'(o_wr), 32'h1);
        step(4'b1111, 4'b1111, 1'b0);
        chk("bubble_busy", 32'(o_busy), 32'h0);
        step(4'b1111, 4'b1111, 1'b0);
        chk("second_grant", 32'(o_grant), 32'b0010);
        step(4'b0000, 4'b0000, 1'b0);

        // Requester 2: three beats A1..A3.
        dat[2] = 8'hA1;
        step(4'b0100, 4'b0000, 1'b0);
        chk("r2_idle_grant", 32'(o_grant), 32'h0);
        step(4'b0100, 4'b0000, 1'b0);
        chk("r2_grant", 32'(o_grant), 32'b0100);
        chk("r2_d1", 32'(o_data), 32'hA1);
        dat[2] = 8'hA2;
        step(4'b0100, 4'b0000, 1'b0);
        chk("r2_d2", 32'(o_data), 32'hA2);
        dat[2] = 8'hA3;
        step(4'b0100, 4'b0100, 1'b0);
        chk("r2_d3", 32'(o_data), 32'hA3);
        chk("r2_wr3", 32'(o_wr), 32'h1);
        step(4'b0000, 4'b0000, 1'b0);
        chk("r2_done_busy", 32'(o_busy), 32'h0);
        step(4'b1111, 4'b0000, 1'b0);
        step(4'b1111, 4'b1000, 1'b0);
        chk("rr_after_r2", 32'(o_grant), 32'b1000);
        step(4'b0000, 4'b0000, 1'b0);

        // Requester 0: 12 beats, forced release after 8.
        step(4'b0001, 4'b0000, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            dat[0] = W'(k);
            step(4'b0001, 4'b0000, 1'b0);
            chk("mb_wr", 32'(o_wr), 32'h1);
            chk("mb_data", 32'(o_data), 32'(k));
        end
        step(4'b0001, 4'b0000, 1'b0);
        chk("mb_release_busy", 32'(o_busy), 32'h0);
        chk("mb_release_wr", 32'(o_wr), 32'h0);
        for (int k = 9; k <= 12; k++) begin
            dat[0] = W'(k);
            step(4'b0001, (k == 12) ? 4'b0001 : 4'b0000, 1'b0);
            chk("mb2_grant", 32'(o_grant), 32'b0001);
            chk("mb2_data", 32'(o_data), 32'(k));
        end
        step(4'b0000, 4'b0000, 1'b0);

        // Requester 1: full stall of 5 cycles after beat 2.
        step(4'b0010, 4'b0000, 1'b0);
        step(4'b0010, 4'b0000, 1'b0);
        step(4'b0010, 4'b0000, 1'b0);
        chk("full_pre_wr", 32'(o_wr), 32'h1);
        for (int k = 0; k < 5; k++) begin
            step(4'b0010, 4'b0010, 1'b1);
            chk("full_grant", 32'(o_grant), 32'b0010);
            chk("full_ack", 32'(o_ack), 32'h0);
            chk("full_wr", 32'(o_wr), 32'h0);
        end
        dat[1] = 8'h33;
        step(4'b0010, 4'b0010, 1'b0);
        chk("full_beat3", 32'(o_data), 32'h33);
        chk("full_beat3_wr", 32'(o_wr), 32'h1);
        step(4'b0000, 4'b0000, 1'b0);

        // Requester 1 abandons after one beat.
        step(4'b0010, 4'b0000, 1'b0);
        step(4'b0010, 4'b0000, 1'b0);
        step(4'b0000, 4'b0000, 1'b0);
        chk("abandon_wr", 32'(o_wr), 32'h0);
        chk("abandon_busy", 32'(o_busy), 32'h1);
        step(4'b0000, 4'b0000, 1'b0);
        chk("abandon_idle", 32'(o_busy), 32'h0);
        step(4'b1111, 4'b0000, 1'b0);
        step(4'b1111, 4'b0100, 1'b0);
        chk("abandon_rr", 32'(o_grant), 32'b0100);

        // Fairness: all requesting, one-beat bursts.
        for (int i = 0; i < N; i++) wr_per[i] = 0;
        for (int k = 0; k < 400; k++) step(4'b1111, 4'b1111, 1'b0);
        for (int i = 0; i < N; i++) chk("fair_share", 32'(wr_per[i]), 32'd50);

        // Asynchronous reset in the middle of a burst.
        step(4'b0000, 4'b0000, 1'b0);
        step(4'b0100, 4'b0000, 1'b0);
        step(4'b0100, 4'b0000, 1'b0);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_grant", 32'(grant), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_wr", 32'(fifo_wr_en), 32'h0);
        chk("mid_rst_data", 32'(fifo_data), 32'h0);
        model_reset();
        #1 reset = 1'b0;
        eval_cycle();

        // Randomized traffic with burst lengths, abandons and full stalls.
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < N; i++) begin
                if (rem[i] == 0 && $urandom_range(3) == 0) begin
                    rem[i] = int'($urandom_range(12, 1));
                    dat[i] = W'($urandom);
                end else if (rem[i] > 0 && $urandom_range(63) == 0) begin
                    rem[i] = 0;
                end
                r[i] = (rem[i] > 0);
                l[i] = (rem[i] == 1);
            end
            f = ($urandom_range(3) == 0);
            step(r, l, f);
            for (int i = 0; i < N; i++) begin
                if (o_ack[i] && rem[i] > 0) begin
                    rem[i]--;
                    dat[i] = W'($urandom);
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares the write side of one asynchronous FIFO among NUM_REQ requesters. It runs entirely in the FIFO's write clock domain, grants one requester at a time for a burst of up to MAX_BURST beats, drives the FIFO write enable and data, and honours the FIFO's full flag.

## Interface

Parameters:
- WIDTH, 8: data word width; equals the FIFO data width.
- NUM_REQ, 4: number of requesters, 2..8.
- MAX_BURST, 8: maximum beats per grant, 1..255.

Ports:
- wr_clk  input  1  FIFO write-domain clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  NUM_REQ  per-requester "has data" request; level, held until the burst is done.
- req_data  input  NUM_REQ*WIDTH  requester i data in bits [i*WIDTH +: WIDTH].
- req_last  input  NUM_REQ  marks the current beat of requester i as the final beat of its burst.
- grant  output  NUM_REQ  registered one-hot grant; all zero when idle.
- ack  output  NUM_REQ  combinational; beat of requester i written this cycle.
- fifo_full  input  1  FIFO write-side full flag.
- fifo_wr_en  output  1  combinational write strobe to the FIFO.
- fifo_data  output  WIDTH  combinational write data to the FIFO.
- busy  output  1  registered; high while a grant is held.

## Operation

- States:
  - IDLE: grant = 0, busy = 0.
  - BURST: exactly one grant bit set, busy = 1.
- Round-robin pointer rr_ptr, reset 0. It gives the highest-priority index.
- IDLE -> BURST when req != 0.
  - Winner is the first set req bit searching from rr_ptr upward, with wrap-around modulo NUM_REQ.
  - Registered grant asserts on the next edge.
  - Beat counter clears to 0.
- A beat is transferred in BURST in any cycle where req[g] = 1 and fifo_full = 0 (g is the granted index). In that cycle:
  - fifo_wr_en = 1.
  - fifo_data = req_data slice g.
  - ack[g] = 1.
  - Beat counter increments.
- When no beat transfers:
  - fifo_wr_en = 0, ack = 0.
  - fifo_data = slice g in BURST, 0 in IDLE.
- fifo_full = 1 stalls the burst. Grant is held, no ack, and the beat counter is frozen.
- BURST -> IDLE on any of the following:
  - A transferred beat with req_last[g] = 1.
  - A transferred beat that makes the count equal MAX_BURST (forced release; the requester re-requests for the remainder).
  - req[g] = 0 in any BURST cycle (requester abandons; no write that cycle).
- On every BURST -> IDLE transition, rr_ptr <= (g+1) mod NUM_REQ.
- Requests from non-granted requesters are ignored until IDLE. They are never lost while held.
- ack and fifo_wr_en are never high for a non-granted index. At most one ack bit is ever set.
- Beat counter width is clog2(MAX_BURST+1) and never wraps.

## Timing

- Reset (asynchronous, immediate), outputs:
  - grant = 0, busy = 0.
  - ack = 0, fifo_wr_en = 0, fifo_data = 0.
  - State IDLE, rr_ptr = 0, beat counter 0.
- Grant latency: req rising in cycle N gives grant in cycle N+1. The first beat can be written in N+1 if fifo_full = 0.
- Throughput inside a burst: one beat per wr_clk while not full.
- One IDLE bubble cycle always separates consecutive grants, including re-granting the same requester.
- fifo_full is sampled combinationally in the same cycle as fifo_wr_en. Because the FIFO's full flag is pessimistic (synchronized read pointer), the arbiter never writes when fifo_full = 1.
- Simultaneous req_last and MAX_BURST on the same beat: single release, rr_ptr advances once.
- req_last while fifo_full = 1: no release until the beat actually transfers.
- Reset mid-burst: grant drops immediately. A partially written burst stays in the FIFO; the requester restarts after reset.

## Test plan

- Reset with req = 4'b1111 held: all outputs 0 during reset. First edge after release gives grant = 4'b0001; next grant after that burst is 4'b0010.
- Requester 2 sends 3 beats 0xA1, 0xA2, 0xA3 with req_last on the third, fifo_full = 0:
  - grant = 4'b0100 one cycle after req.
  - fifo_wr_en high 3 consecutive cycles with data A1, A2, A3.
  - busy drops next cycle; rr_ptr = 3.
- MAX_BURST = 8; requester 0 streams 12 beats with no req_last:
  - Release after beat 8.
  - One idle cycle, then grant = 4'b0001 again if no other req; beats 9–12 follow.
- fifo_full asserted for 5 cycles mid-burst after beat 2:
  - Grant held, no ack/wr_en for 5 cycles.
  - Beat 3 data written on the first cycle full = 0; total beat count unchanged.
- Requester 1 deasserts req after 1 beat without req_last: return to IDLE next edge, rr_ptr = 2, no further writes.
- Fairness: req = 4'b1111 permanently, each burst 1 beat with req_last. Grant sequence is 0, 1, 2, 3, 0, … with exactly one bubble between grants; each index gets 25% of writes over 400 cycles.
